// File: rtl/rotate_seq_ctrl.sv
// Rotation sequencer for the 4-digit rotating-segment display: step/direction/enable
// generation with a prescaled step rate, run/pause/single-step control and a lap counter.
module rotate_seq_ctrl #(
    parameter int unsigned TICK_DIV = 25_000_000,
    parameter int unsigned LAP_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step_req,
    input  logic             dir_in,
    output logic [2:0]       step,
    output logic             cw,
    output logic             en,
    output logic             step_tick,
    output logic [LAP_W-1:0] lap,
    output logic [1:0]       state
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t          st;
    logic [PW-1:0]   presc;
    logic [2:0]      adv_step;
    logic            adv_wrap;
    logic [LAP_W-1:0] adv_lap;

    assign state = st;

    // Result of one advance event; direction is taken fresh from dir_in.
    always_comb begin
        adv_step = dir_in ? (step + 3'd1) : (step - 3'd1);
        adv_wrap = dir_in ? (step == 3'd7) : (step == 3'd0);
        adv_lap  = lap;
        if (adv_wrap && (lap != '1)) begin
            adv_lap = lap + LAP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= IDLE;
            step      <= 3'd0;
            cw        <= 1'b1;
            en        <= 1'b0;
            step_tick <= 1'b0;
            lap       <= '0;
            presc     <= '0;
        end else begin
            step_tick <= 1'b0;
            case (st)
                IDLE: begin
                    if (start && !stop) begin
                        st    <= RUN;
                        en    <= 1'b1;
                        step  <= 3'd0;
                        lap   <= '0;
                        presc <= '0;
                        cw    <= dir_in;
                    end
                end
                RUN: begin
                    // stop freezes the prescaler and suppresses a coincident advance
                    if (stop) begin
                        st <= PAUSE;
                    end else if (presc == PMAX) begin
                        presc     <= '0;
                        cw        <= dir_in;
                        step      <= adv_step;
                        lap       <= adv_lap;
                        step_tick <= 1'b1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        st   <= IDLE;
                        en   <= 1'b0;
                        step <= 3'd0;
                    end else if (start) begin
                        st <= RUN;
                    end else if (step_req) begin
                        cw        <= dir_in;
                        step      <= adv_step;
                        lap       <= adv_lap;
                        step_tick <= 1'b1;
                    end
                end
                default: begin
                    st <= IDLE;
                    en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Directed bench for rotate_seq_ctrl: expected advances are queued as stimulus is
// issued and a negedge monitor checks each step_tick against the queue.
module tb_rotate_seq_ctrl;

    localparam int unsigned TD = 4;

    logic clk;
    logic rst_a, rst_b;
    logic start, stop, step_req, dir_in;

    logic [2:0] step1, step2;
    logic       cw1, cw2, en1, en2, tick1, tick2;
    logic [7:0] lap1;
    logic [1:0] lap2;
    logic [1:0] state1, state2;

    typedef struct packed {
        logic [2:0] step;
        logic       cw;
        logic [7:0] lap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    rotate_seq_ctrl #(.TICK_DIV(TD), .LAP_W(8)) dut (
        .clk(clk), .reset(rst_a), .start(start), .stop(stop), .step_req(step_req),
        .dir_in(dir_in), .step(step1), .cw(cw1), .en(en1), .step_tick(tick1),
        .lap(lap1), .state(state1)
    );

    rotate_seq_ctrl #(.TICK_DIV(TD), .LAP_W(2)) dut_sat (
        .clk(clk), .reset(rst_b), .start(start), .stop(stop), .step_req(step_req),
        .dir_in(dir_in), .step(step2), .cw(cw2), .en(en2), .step_tick(tick2),
        .lap(lap2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic c, input logic [7:0] l);
        exp_t x;
        x.step = s;
        x.cw   = c;
        x.lap  = l;
        q.push_back(x);
    endtask

    // Called on a negedge; holds the pulse across exactly one rising edge.
    task automatic pulse(input logic s, input logic p, input logic r);
        start = s; stop = p; step_req = r;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; step_req = 1'b0;
    endtask

    task automatic wait_tick(input bit which, output int n);
        logic t;
        n = 0;
        t = 1'b0;
        while (!t && n < 64) begin
            @(negedge clk);
            n++;
            t = which ? tick2 : tick1;
        end
        if (!t) begin
            n_vec++;
            n_err++;
            $display("FAIL tick_timeout: no step_tick on dut %0d within %0d cycles", which, n);
        end
    endtask

    task automatic chk_reset1(input string nm);
        chk({nm, "_state"}, 32'(state1), 32'd0);
        chk({nm, "_step"},  32'(step1),  32'd0);
        chk({nm, "_cw"},    32'(cw1),    32'd1);
        chk({nm, "_en"},    32'(en1),    32'd0);
        chk({nm, "_tick"},  32'(tick1),  32'd0);
        chk({nm, "_lap"},   32'(lap1),   32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst_a && tick1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected_tick: got step=%0d expected no advance (t=%0t)", step1, $time);
            end else begin
                e = q.pop_front();
                chk("sb_step", 32'(step1), 32'(e.step));
                chk("sb_cw",   32'(cw1),   32'(e.cw));
                chk("sb_lap",  32'(lap1),  32'(e.lap));
            end
        end
    end

    initial begin
        int n;
        rst_a = 1'b0; rst_b = 1'b0;
        start = 1'b0; stop = 1'b0; step_req = 1'b0; dir_in = 1'b1;
        #2;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        chk_reset1("rst");
        @(negedge clk);
        rst_a = 1'b0;

        // Clockwise run: 8 advances, lap 1 on the 7->0 wrap
        for (int k = 1; k <= 8; k++) push(3'(k), 1'b1, (k == 8) ? 8'd1 : 8'd0);
        dir_in = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        chk("start_state", 32'(state1), 32'd1);
        chk("start_en", 32'(en1), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            wait_tick(1'b0, n);
            chk("run_interval", 32'(n), 32'(TD));
        end
        chk("lap_after_8", 32'(lap1), 32'd1);
        chk("step_after_8", 32'(step1), 32'd0);

        // Pause with prescaler at 2, then freeze for 20 cycles
        @(negedge clk);
        @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        chk("pause_state", 32'(state1), 32'd2);
        chk("pause_en", 32'(en1), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("frozen_step", 32'(step1), 32'd0);
        end

        // Three single steps
        for (int k = 1; k <= 3; k++) push(3'(k), 1'b1, 8'd1);
        for (int k = 1; k <= 3; k++) begin
            pulse(1'b0, 1'b0, 1'b1);
            chk("single_step", 32'(step1), 32'(k));
            @(negedge clk);
        end
        chk("pause_hold_state", 32'(state1), 32'd2);

        // Resume: prescaler continues from 2, so the advance comes 2 cycles later
        push(3'd4, 1'b1, 8'd1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("resume_state", 32'(state1), 32'd1);
        wait_tick(1'b0, n);
        chk("resume_latency", 32'(n), 32'd2);

        // PAUSE with start+step_req: back to RUN, no extra step
        pulse(1'b0, 1'b1, 1'b0);
        chk("pause2_state", 32'(state1), 32'd2);
        pulse(1'b1, 1'b0, 1'b1);
        chk("start_beats_req_state", 32'(state1), 32'd1);
        chk("start_beats_req_step", 32'(step1), 32'd4);
        push(3'd5, 1'b1, 8'd1);
        wait_tick(1'b0, n);
        chk("rerun_latency", 32'(n), 32'(TD));

        // Reverse at step 5 -> 4, lap unchanged
        dir_in = 1'b0;
        push(3'd4, 1'b0, 8'd1);
        wait_tick(1'b0, n);
        chk("reverse_latency", 32'(n), 32'(TD));
        chk("reverse_cw", 32'(cw1), 32'd0);

        // RUN with start+stop -> PAUSE; then stop -> IDLE keeps lap
        pulse(1'b1, 1'b1, 1'b0);
        chk("stop_beats_start", 32'(state1), 32'd2);
        pulse(1'b0, 1'b1, 1'b0);
        chk("idle_state", 32'(state1), 32'd0);
        chk("idle_en", 32'(en1), 32'd0);
        chk("idle_step", 32'(step1), 32'd0);
        chk("idle_lap_held", 32'(lap1), 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        chk("idle_ignores_state", 32'(state1), 32'd0);
        chk("idle_ignores_step", 32'(step1), 32'd0);

        // Counter-clockwise from start: 0,7,6,...; 18 advances reach step 6, lap 3
        for (int k = 1; k <= 18; k++) push(3'(8 - (k % 8)), 1'b0, 8'((k + 7) / 8));
        dir_in = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        chk("ccw_state", 32'(state1), 32'd1);
        chk("ccw_cw", 32'(cw1), 32'd0);
        chk("ccw_lap_cleared", 32'(lap1), 32'd0);
        for (int k = 1; k <= 18; k++) begin
            wait_tick(1'b0, n);
            chk("ccw_interval", 32'(n), 32'(TD));
        end
        chk("ccw_step6", 32'(step1), 32'd6);
        chk("ccw_lap3", 32'(lap1), 32'd3);

        // Asynchronous reset mid-cycle
        #1 rst_a = 1'b1;
        #1 chk_reset1("async_rst");
        chk("sb_empty", 32'(q.size()), 32'd0);
        @(negedge clk);

        // Saturating lap on the LAP_W=2 instance
        rst_b = 1'b0;
        dir_in = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        chk("sat_state", 32'(state2), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            wait_tick(1'b1, n);
            chk("sat_step", 32'(step2), 32'(k % 8));
            if (k % 8 == 0) chk("sat_lap", 32'(lap2), (k / 8 > 3) ? 32'd3 : 32'(k / 8));
        end
        chk("sat_final", 32'(lap2), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rotate_seq_ctrl.md
Name: rotate_seq_ctrl

Overview:
Sequencer for the 4-digit rotating-segment display. Generates the 3-bit rotation step (0..7), direction and enable that drive the segment/anode pattern lookup. Provides a prescaled step rate, run/pause/single-step control and a lap counter. Sits between the debounced button/switch logic and the pattern lookup.

Parameters:
TICK_DIV, 25_000_000, clk cycles per rotation step in RUN (min 2); prescaler width is clog2(TICK_DIV)
LAP_W, 8, width of the lap counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
start  in  1  single-cycle pulse: begin or resume rotation
stop  in  1  single-cycle pulse: pause, or return to idle if already paused
step_req  in  1  single-cycle pulse: advance one step (PAUSE only)
dir_in  in  1  requested direction, 1 = clockwise
step  out  3  current rotation step to pattern lookup
cw  out  1  direction in effect, to pattern lookup
en  out  1  display enable
step_tick  out  1  one-cycle strobe, high in the cycle after each step update
lap  out  LAP_W  completed full rotations, saturating
state  out  2  00 IDLE, 01 RUN, 10 PAUSE

Behaviour:
- All outputs are registered. Inputs are synchronous, already debounced, and single-cycle.
- Reset (async, any time, including mid-rotation): state=IDLE, step=0, cw=1, en=0, step_tick=0, lap=0, prescaler=0.
- IDLE:
  - en=0.
  - start -> RUN. In the same edge: step<=0, lap<=0, prescaler<=0, cw<=dir_in.
  - stop and step_req are ignored.
- RUN:
  - en=1. The prescaler counts 0..TICK_DIV-1.
  - At count TICK_DIV-1 (an "advance" event), the prescaler wraps to 0 and the step advances.
  - The first advance occurs TICK_DIV cycles after the cycle in which state becomes RUN.
- Advance event, common to RUN tick and PAUSE step_req:
  - cw<=dir_in, i.e. the direction is sampled only at advances.
  - Step moves in the new direction: cw=1 gives step+1 mod 8; cw=0 gives step-1 mod 8.
  - step_tick<=1 for exactly one cycle.
  - lap increments when the step wraps 7->0 (cw) or 0->7 (ccw), saturating at 2^LAP_W-1.
- RUN + stop -> PAUSE. The prescaler holds its value, and no advance occurs in that cycle even if the prescaler is at TICK_DIV-1. start in RUN is ignored.
- PAUSE:
  - en=1; the display is frozen on the current step and the prescaler is held.
  - step_req causes one advance event.
  - start -> RUN, resuming from the held prescaler value.
  - stop -> IDLE: en<=0, step<=0; lap is held until the next start.
- Simultaneous events: stop beats start in every state. start beats step_req in PAUSE (no step taken). step_req outside PAUSE is ignored.
- Latency: a control pulse in cycle N is reflected in state/en at cycle N+1.
- Direction changes mid-lap: step continues from its current value. The lap counts only true wraps, not reversals.
- Illegal state encoding 11 recovers to IDLE on the next clock.

Test Plan:
- TICK_DIV=4. Reset, start with dir_in=1 at cycle 0 -> state=01 and en=1 at cycle 1; step goes 1,2,3,... every 4 cycles; step_tick is a single-cycle pulse on each advance; after 8 advances step=0 and lap=1.
- dir_in=0 from start -> step goes 0,7,6,...; lap=1 on the first 0->7 wrap; cw=0.
- RUN, stop at prescaler=2 -> state=10 and step frozen for 20 cycles. Then 3 step_req pulses -> step +3 and 3 step_tick pulses. Then start -> next advance exactly 2 cycles later (prescaler resumed from 2).
- PAUSE with start and step_req in the same cycle -> RUN, no extra step. RUN with start and stop in the same cycle -> PAUSE.
- dir_in toggled 1->0 between advances at step=5 -> next advance gives step=4, cw=0, lap unchanged.
- Assert reset mid-RUN at step=6, lap=3 -> all outputs return to reset values asynchronously, before the next clk edge. LAP_W=2 with 5 laps run -> lap saturates at 3.
